// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: valid/ready handshake, 2-entry skid, flush.
// Define PIPE_STAGE_PERF_EN to add stall/bubble/flush performance counters.
module pipe_stage_reg #(
  parameter int CTRL_W     = 16,
  parameter int DATA_W     = 128,
  parameter int CLEAR_DATA = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [CTRL_W-1:0] i_in_ctrl,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [CTRL_W-1:0] o_out_ctrl,
`ifdef PIPE_STAGE_PERF_EN
  output logic [31:0]       o_stall_cnt,
  output logic [31:0]       o_bubble_cnt,
  output logic [15:0]       o_flush_cnt,
`endif
  output logic [DATA_W-1:0] o_out_data
);

  // bit0 = main slot valid, bit1 = skid slot valid
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b01,
    S_TWO   = 2'b11
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;

  logic w_accept;
  logic w_drain;
  logic w_ld_main_in;
  logic w_ld_main_skid;
  logic w_ld_skid;
  logic w_clr_main;

  assign o_out_valid = r_state[0];
  assign o_in_ready  = ~r_state[1];
  assign o_out_ctrl  = r_main_ctrl;
  assign o_out_data  = r_main_data;

  assign w_accept = i_in_valid & o_in_ready;
  assign w_drain  = o_out_valid & i_out_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    w_clr_main     = 1'b0;
    unique case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_state_nxt  = S_ONE;
          w_ld_main_in = 1'b1;
        end
      end
      S_ONE: begin
        if (w_accept && w_drain) begin
          w_ld_main_in = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = S_TWO;
          w_ld_skid   = 1'b1;
        end else if (w_drain) begin
          w_state_nxt = S_EMPTY;
          w_clr_main  = 1'b1;
        end
      end
      S_TWO: begin
        if (w_drain) begin
          w_state_nxt    = S_ONE;
          w_ld_main_skid = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_EMPTY;
        w_clr_main  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_state     <= S_EMPTY;
      r_main_ctrl <= '0;
      r_skid_ctrl <= '0;
      if (CLEAR_DATA != 0) begin
        r_main_data <= '0;
        r_skid_data <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      if (w_ld_main_in) begin
        r_main_ctrl <= i_in_ctrl;
        r_main_data <= i_in_data;
      end else if (w_ld_main_skid) begin
        r_main_ctrl <= r_skid_ctrl;
        r_main_data <= r_skid_data;
      end else if (w_clr_main) begin
        r_main_ctrl <= '0;
      end
      if (w_ld_skid) begin
        r_skid_ctrl <= i_in_ctrl;
        r_skid_data <= i_in_data;
      end
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  // Counters ignore flush so they survive pipeline kills
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_stall_cnt  <= '0;
      o_bubble_cnt <= '0;
      o_flush_cnt  <= '0;
    end else begin
      if (o_out_valid && !i_out_ready) begin
        o_stall_cnt <= o_stall_cnt + 32'd1;
      end
      if (!o_out_valid) begin
        o_bubble_cnt <= o_bubble_cnt + 32'd1;
      end
      if (i_flush) begin
        o_flush_cnt <= o_flush_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: vector table, corner sequences, random vs queue model.
// Counter checks are compiled in when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_reg;
  localparam int CW  = 16;
  localparam int DW  = 128;
  localparam int CW1 = 8;
  localparam int DW1 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;

  logic           b_rst = 1'b1;
  logic           b_flush = 1'b0;
  logic           b_iv = 1'b0;
  logic           b_ordy = 1'b0;
  logic [CW1-1:0] b_ctrl = '0;
  logic [DW1-1:0] b_data = '0;
  logic           b_ir;
  logic           b_ov;
  logic [CW1-1:0] b_octrl;
  logic [DW1-1:0] b_odata;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] bubble_cnt;
  logic [15:0] flush_cnt;
  logic [31:0] m_stall;
  logic [31:0] m_bubble;
  logic [15:0] m_flush;
`endif

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_ctrl(in_ctrl), .i_in_data(in_data),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_ctrl(out_ctrl),
`ifdef PIPE_STAGE_PERF_EN
    .o_stall_cnt(stall_cnt), .o_bubble_cnt(bubble_cnt),
    .o_flush_cnt(flush_cnt),
`endif
    .o_out_data(out_data)
  );

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] b_sc;
  logic [31:0] b_bc;
  logic [15:0] b_fc;
`endif

  pipe_stage_reg #(.CTRL_W(CW1), .DATA_W(DW1), .CLEAR_DATA(0)) dut_hold (
    .i_clk(clk), .i_rst(b_rst), .i_flush(b_flush),
    .i_in_valid(b_iv), .o_in_ready(b_ir),
    .i_in_ctrl(b_ctrl), .i_in_data(b_data),
    .o_out_valid(b_ov), .i_out_ready(b_ordy),
    .o_out_ctrl(b_octrl),
`ifdef PIPE_STAGE_PERF_EN
    .o_stall_cnt(b_sc), .o_bubble_cnt(b_bc),
    .o_flush_cnt(b_fc),
`endif
    .o_out_data(b_odata)
  );

  // Reference: a FIFO of at most two entries; out_* shows its head.
  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;
  ent_t        q[$];
  ent_t        m_e;
  logic [DW-1:0] m_data = '0;
  bit          m_acc;
  bit          m_drn;

  always @(posedge clk) begin
`ifdef PIPE_STAGE_PERF_EN
    if (rst) begin
      m_stall = '0; m_bubble = '0; m_flush = '0;
    end else begin
      if (q.size() > 0 && !out_ready) m_stall = m_stall + 1;
      if (q.size() == 0) m_bubble = m_bubble + 1;
      if (flush) m_flush = m_flush + 1;
    end
`endif
    if (rst || flush) begin
      q.delete();
      m_data = '0;
    end else begin
      m_acc = in_valid && (q.size() < 2);
      m_drn = (q.size() > 0) && out_ready;
      m_e.c = in_ctrl;
      m_e.d = in_data;
      if (m_drn) void'(q.pop_front());
      if (m_acc) q.push_back(m_e);
    end
    if (q.size() > 0) m_data = q[0].d;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_in();
    flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
  endtask

  task automatic do_reset(input int n);
    idle_in();
    out_ready = 1'b0;
    rst = 1'b1;
    repeat (n) cyc();
    rst = 1'b0;
  endtask

  typedef struct {
    logic          iv;
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    logic          ordy;
    logic          eov;
    logic [CW-1:0] ectrl;
    logic [DW-1:0] edat;
    logic          eir;
  } vec_t;
  vec_t tbl[11];

  logic [DW-1:0] got[$];
  int nxt;

  initial begin
    for (int k = 0; k < 11; k++) begin
      tbl[k].iv    = (k < 10);
      tbl[k].c     = CW'(k + 1) | 16'h0100;
      tbl[k].d     = DW'(k + 1);
      tbl[k].ordy  = 1'b1;
      tbl[k].eov   = (k < 10);
      tbl[k].ectrl = (k < 10) ? (CW'(k + 1) | 16'h0100) : '0;
      tbl[k].edat  = (k < 10) ? DW'(k + 1) : DW'(10);
      tbl[k].eir   = 1'b1;
    end

    @(negedge clk);
    do_reset(2);
    chk("rst_ov", DW'(out_valid), DW'(0));
    chk("rst_ir", DW'(in_ready), DW'(1));
    chk("rst_ctrl", DW'(out_ctrl), DW'(0));
    chk("rst_data", out_data, DW'(0));

`ifdef PIPE_STAGE_PERF_EN
    chk("perf_rst_stall", DW'(stall_cnt), DW'(0));
    chk("perf_rst_bubble", DW'(bubble_cnt), DW'(0));
    chk("perf_rst_flush", DW'(flush_cnt), DW'(0));
    repeat (3) cyc();
    in_valid = 1'b1; in_data = DW'(8'h44); in_ctrl = 16'h1;
    cyc();
    idle_in();
    repeat (4) cyc();
    out_ready = 1'b1;
    flush = 1'b1;
    repeat (2) cyc();
    flush = 1'b0;
    chk("perf_stall", DW'(stall_cnt), DW'(4));
    chk("perf_flush", DW'(flush_cnt), DW'(2));
    chk("perf_bubble", DW'(bubble_cnt), DW'(5));
    chk("perf_bubble_m", DW'(bubble_cnt), DW'(m_bubble));
    do_reset(1);
    chk("perf_clr_stall", DW'(stall_cnt), DW'(0));
    chk("perf_clr_bubble", DW'(bubble_cnt), DW'(0));
    chk("perf_clr_flush", DW'(flush_cnt), DW'(0));
`endif

    // Streaming at full throughput
    for (int k = 0; k < 11; k++) begin
      in_valid  = tbl[k].iv;
      in_ctrl   = tbl[k].c;
      in_data   = tbl[k].d;
      out_ready = tbl[k].ordy;
      cyc();
      chk($sformatf("strm%0d_ov", k), DW'(out_valid), DW'(tbl[k].eov));
      chk($sformatf("strm%0d_ctrl", k), DW'(out_ctrl), DW'(tbl[k].ectrl));
      chk($sformatf("strm%0d_data", k), out_data, tbl[k].edat);
      chk($sformatf("strm%0d_ir", k), DW'(in_ready), DW'(tbl[k].eir));
    end

    // Backpressure: stall 3 cycles right after entry 1 is accepted
    do_reset(1);
    got.delete();
    nxt = 1;
    for (int c = 0; c < 20; c++) begin
      if (c == 2) begin
        chk("bp_ir", DW'(in_ready), DW'(0));
        chk("bp_ov", DW'(out_valid), DW'(1));
        chk("bp_hold", out_data, DW'(1));
      end
      out_ready = !(c >= 1 && c <= 3);
      if (out_valid && out_ready) got.push_back(out_data);
      in_valid = (nxt <= 6);
      in_ctrl  = CW'(nxt);
      in_data  = DW'(nxt);
      if (in_valid && in_ready) nxt++;
      cyc();
    end
    idle_in();
    chk("bp_count", DW'(got.size()), DW'(6));
    for (int i = 0; i < 6; i++) begin
      if (i < got.size()) chk($sformatf("bp_ord%0d", i), got[i], DW'(i + 1));
      else chk($sformatf("bp_ord%0d", i), DW'(0), DW'(i + 1));
    end

    // Flush while both slots are full
    do_reset(1);
    in_valid = 1'b1; in_ctrl = 16'h00AA; in_data = DW'(8'h0A);
    cyc();
    in_ctrl = 16'h00BB; in_data = DW'(8'h0B);
    cyc();
    chk("fl_two", DW'(in_ready), DW'(0));
    flush = 1'b1; in_ctrl = 16'h00CC; in_data = DW'(8'h0C);
    cyc();
    idle_in();
    chk("fl_ov", DW'(out_valid), DW'(0));
    chk("fl_ctrl", DW'(out_ctrl), DW'(0));
    chk("fl_data", out_data, DW'(0));
    chk("fl_ir", DW'(in_ready), DW'(1));
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("fl_noC%0d", i), DW'(out_valid), DW'(0));
    end

    // Data held through flush when clearing is disabled
    b_rst = 1'b1;
    cyc();
    b_rst = 1'b0;
    b_iv = 1'b1; b_ctrl = 8'h03; b_data = 16'h0055;
    cyc();
    b_iv = 1'b0;
    chk("hold_ov1", DW'(b_ov), DW'(1));
    chk("hold_d1", DW'(b_odata), DW'(16'h0055));
    b_flush = 1'b1;
    cyc();
    b_flush = 1'b0;
    chk("hold_ov", DW'(b_ov), DW'(0));
    chk("hold_ctrl", DW'(b_octrl), DW'(0));
    chk("hold_data", DW'(b_odata), DW'(16'h0055));

    // Reset together with flush while stalled in TWO
    do_reset(1);
    in_valid = 1'b1; in_ctrl = 16'h1; in_data = DW'(1);
    cyc();
    in_ctrl = 16'h2; in_data = DW'(2);
    cyc();
    chk("rs_two", DW'(in_ready), DW'(0));
    rst = 1'b1; flush = 1'b1; in_data = DW'(9);
    cyc();
    rst = 1'b0; flush = 1'b0;
    chk("rs_ov", DW'(out_valid), DW'(0));
    chk("rs_ir", DW'(in_ready), DW'(1));
    chk("rs_ctrl", DW'(out_ctrl), DW'(0));
    chk("rs_data", out_data, DW'(0));
    in_valid = 1'b1; in_ctrl = 16'h7; in_data = DW'(7); out_ready = 1'b1;
    cyc();
    idle_in();
    chk("rs_new_ov", DW'(out_valid), DW'(1));
    chk("rs_new_data", out_data, DW'(7));

    // Random traffic against the queue model
    do_reset(1);
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom % 64) == 0;
      flush     = ($urandom % 16) == 0;
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      in_ctrl   = CW'($urandom);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      cyc();
      chk("rnd_ov", DW'(out_valid), DW'(q.size() > 0));
      chk("rnd_ir", DW'(in_ready), DW'(q.size() < 2));
      chk("rnd_ctrl", DW'(out_ctrl), (q.size() > 0) ? DW'(q[0].c) : DW'(0));
      chk("rnd_data", out_data, m_data);
    end
    rst = 1'b0;
    idle_in();
`ifdef PIPE_STAGE_PERF_EN
    chk("rnd_stall", DW'(stall_cnt), DW'(m_stall));
    chk("rnd_bubble", DW'(bubble_cnt), DW'(m_bubble));
    chk("rnd_flush", DW'(flush_cnt), DW'(m_flush));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the pipelined CPU core.
- Successor to the fixed per-stage latch: one instance carries a control bundle and a data bundle between any two stages.
- Adds a valid/ready handshake, a 2-entry skid buffer (registered in_ready, no combinational ready path), and flush with bubble insertion.
- Sits between IF/ID, ID/EX, EX/MEM and MEM/WB; stall is expressed as downstream backpressure.

Parameters:
- CTRL_W, 16: width of the control bundle (RegWrite, MemWrite, ALUOp...). Always zeroed on reset/flush.
- DATA_W, 128: width of the data bundle (PC, operands, immediates, register indices).
- CLEAR_DATA, 1: 1 = data bundle zeroed on reset/flush; 0 = data holds its previous value and only valid/ctrl clear.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of all held entries (branch/jump mispredict, load-use bubble).
- in_valid  in  1  upstream entry present.
- in_ready  out  1  register can accept; registered, equals !skid_valid.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  output entry present.
- out_ready  in  1  downstream accepts (0 = stall).
- out_ctrl  out  CTRL_W  registered control; all-zero whenever out_valid=0.
- out_data  out  DATA_W  registered data.

Behaviour:
- Storage: main slot (drives out_*), skid slot (skid_valid, skid_ctrl, skid_data). All outputs come straight from flops.
- Transfers: accept = in_valid && in_ready; drain = out_valid && out_ready.
- States: EMPTY (out_valid=0, skid empty), ONE (out_valid=1, skid empty), TWO (out_valid=1, skid full).
- EMPTY:
  - accept -> ONE; main <= in.
  - No accept -> stay; out_ctrl held at 0.
- ONE:
  - accept && drain -> ONE; main <= in.
  - accept && !drain -> TWO; skid <= in; main unchanged.
  - !accept && drain -> EMPTY; out_ctrl <= 0.
  - Neither -> hold.
- TWO:
  - in_ready=0, so no accept.
  - drain -> ONE; main <= skid; skid_valid <= 0.
  - No drain -> hold; both slots stable.
- Latency and throughput:
  - 1 cycle from accept to out_valid.
  - Full throughput: 1 entry/cycle with out_ready held high.
  - Entries are never dropped or duplicated, and order is preserved.
- Flush:
  - Next edge: state EMPTY, out_valid=0, skid_valid=0, out_ctrl=0.
  - out_data and skid_data go to 0 if CLEAR_DATA=1, otherwise hold.
  - An entry accepted in the same cycle as flush is discarded.
  - A drain in the flush cycle still counts as consumed downstream.
- Reset: same effect as flush, and has priority over it. in_ready=1 from the first cycle after reset.
- Simultaneous rst/flush/accept: rst > flush > accept/drain.
- Reset mid-operation: any held entries are lost; no partial state survives.
- Width rules: ctrl and data are passed bit-exact; there is no arithmetic.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- When defined, adds three outputs:
  - stall_cnt (32): counts cycles with out_valid && !out_ready.
  - bubble_cnt (32): counts cycles with out_valid=0.
  - flush_cnt (16): counts cycles with flush=1.
- Counters clear on rst, wrap modulo 2^N, and are unaffected by flush (other than flush_cnt incrementing).
- When undefined, these ports and their logic are absent; the core behaviour is identical in both builds.

Test Plan:
- Streaming: rst 2 cycles, then in_valid=1 with in_data = 1, 2, 3..10 and out_ready=1 -> out_data 1..10 on consecutive cycles, 1 cycle behind input; in_ready stays 1.
- Backpressure: stream 1..6, drop out_ready for 3 cycles after the entry-1 accept:
  - entry 2 goes to skid; in_ready=0 the following cycle; out_data holds 1.
  - On release, 1..6 are delivered in order with no loss.
- Flush in TWO: fill main=0xA, skid=0xB, assert flush with in_valid=1 data 0xC:
  - next cycle out_valid=0, out_ctrl=0, out_data=0 (CLEAR_DATA=1), in_ready=1.
  - 0xC never appears.
- CLEAR_DATA=0 variant: main=0x55 then flush -> out_valid=0, out_ctrl=0, out_data still 0x55.
- Reset mid-stall: TWO state with out_ready=0, assert rst together with flush -> EMPTY next cycle; after release a new entry 0x7 appears 1 cycle after accept.
- PIPE_STAGE_PERF_EN: 4 stall cycles, 2 flushes, 3 empty cycles after reset -> stall_cnt=4, flush_cnt=2, bubble_cnt counts exactly the cycles with out_valid=0; all counters read 0 after rst.
